// File: rtl/pi_pwm_regulator_pkg.sv
// Shared definitions for the PI PWM regulator: datapath widths, FSM states and integrator limits.
package pi_pwm_regulator_pkg;

    localparam int ADC_W   = 12;
    localparam int ERR_W   = 13;
    localparam int INTEG_W = 24;
    localparam int SUM_W   = 26;

    localparam logic signed [INTEG_W-1:0] INTEG_MAX   = 24'sh7FFFFF;
    localparam logic signed [INTEG_W-1:0] INTEG_MIN   = 24'sh800001;
    localparam logic signed [SUM_W-1:0]   INTEG_MAX_X = 26'sh07FFFFF;
    localparam logic signed [SUM_W-1:0]   INTEG_MIN_X = 26'sh3800001;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ERR   = 3'd1,
        ST_INTEG = 3'd2,
        ST_SUM   = 3'd3,
        ST_CLAMP = 3'd4
    } reg_state_e;

    // Symmetric saturation so the integrator can never wrap.
    function automatic logic signed [INTEG_W-1:0] sat_integ(input logic signed [SUM_W-1:0] x);
        if (x > INTEG_MAX_X) begin
            return INTEG_MAX;
        end else if (x < INTEG_MIN_X) begin
            return INTEG_MIN;
        end
        return x[INTEG_W-1:0];
    endfunction

endpackage

// File: rtl/pi_pwm_regulator_pwm.sv
// PWM generator: free-running counter, shadow duty loaded only at wrap, registered compare output.
module pi_pwm_regulator_pwm
    import pi_pwm_regulator_pkg::*;
#(
    parameter int PWM_BITS = 10
) (
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic                enable_i,
    input  logic [PWM_BITS-1:0] duty_i,
    output logic                pwm_o
);
    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic [PWM_BITS-1:0] active_q, active_d;
    logic                pwm_q, pwm_d;

    always_comb begin
        cnt_d    = cnt_q + PWM_BITS'(1);
        active_d = (cnt_q == '1) ? duty_i : active_q;
        pwm_d    = enable_i && (cnt_q < active_q);
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q    <= '0;
            active_q <= '0;
            pwm_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
            pwm_q    <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/pi_pwm_regulator.sv
// PI voltage regulator: samples the averaged voltage every CTRL_PERIOD clocks and sets a PWM duty.
// Define PI_ANTIWINDUP_EN to freeze the integrator while the output is clamped in the error's direction.
module pi_pwm_regulator
    import pi_pwm_regulator_pkg::*;
#(
    parameter int CTRL_PERIOD = 16384,
    parameter int KP          = 16,
    parameter int KI          = 2,
    parameter int GAIN_SHIFT  = 4,
    parameter int PWM_BITS    = 10,
    parameter int DUTY_MAX    = 1023
) (
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic                enable_i,
    input  logic [ADC_W-1:0]    setpoint_i,
    input  logic [ADC_W-1:0]    voltage_i,
    output logic                pwm_out_o,
    output logic [PWM_BITS-1:0] duty_o,
    output logic                update_o,
    output logic                saturated_o
);
    localparam int TICK_W = (CTRL_PERIOD > 1) ? $clog2(CTRL_PERIOD) : 1;
    localparam logic [TICK_W-1:0]       TICK_LAST  = TICK_W'(CTRL_PERIOD - 1);
    localparam logic signed [SUM_W-1:0] KP_S       = SUM_W'(KP);
    localparam logic signed [SUM_W-1:0] KI_S       = SUM_W'(KI);
    localparam logic signed [SUM_W-1:0] DUTY_MAX_S = SUM_W'(DUTY_MAX);

    reg_state_e                state_q, state_d;
    logic [TICK_W-1:0]         tick_cnt_q, tick_cnt_d;
    logic signed [ERR_W-1:0]   err_q, err_d;
    logic signed [INTEG_W-1:0] integ_q, integ_d;
    logic [PWM_BITS-1:0]       duty_q, duty_d;
    logic                      sat_hi_q, sat_hi_d;
    logic                      sat_lo_q, sat_lo_d;

    logic                      tick;
    logic                      hold_integ;
    logic signed [ERR_W-1:0]   err_new;
    logic signed [SUM_W-1:0]   integ_sum;
    logic signed [SUM_W-1:0]   pi_sum;

    assign tick      = enable_i && (tick_cnt_q == TICK_LAST);
    assign err_new   = $signed({1'b0, setpoint_i}) - $signed({1'b0, voltage_i});
    assign integ_sum = SUM_W'(integ_q) + KI_S * SUM_W'(err_q);
    assign pi_sum    = (KP_S * SUM_W'(err_q) + SUM_W'(integ_q)) >>> GAIN_SHIFT;

`ifdef PI_ANTIWINDUP_EN
    assign hold_integ = (sat_hi_q && !err_q[ERR_W-1] && (err_q != '0)) ||
                        (sat_lo_q && err_q[ERR_W-1]);
`else
    assign hold_integ = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        err_d      = err_q;
        integ_d    = integ_q;
        duty_d     = duty_q;
        sat_hi_d   = sat_hi_q;
        sat_lo_d   = sat_lo_q;

        // Disabling aborts any calculation in flight and forgets all loop history.
        if (!enable_i) begin
            state_d    = ST_IDLE;
            tick_cnt_d = '0;
            integ_d    = '0;
            duty_d     = '0;
            sat_hi_d   = 1'b0;
            sat_lo_d   = 1'b0;
        end else begin
            tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
            case (state_q)
                ST_IDLE: begin
                    if (tick) state_d = ST_ERR;
                end
                ST_ERR: begin
                    err_d   = err_new;
                    state_d = ST_INTEG;
                end
                ST_INTEG: begin
                    if (!hold_integ) integ_d = sat_integ(integ_sum);
                    state_d = ST_SUM;
                end
                ST_SUM: begin
                    // Duty is registered here so it appears together with the update pulse.
                    if (pi_sum[SUM_W-1]) begin
                        duty_d   = '0;
                        sat_hi_d = 1'b0;
                        sat_lo_d = 1'b1;
                    end else if (pi_sum > DUTY_MAX_S) begin
                        duty_d   = PWM_BITS'(DUTY_MAX);
                        sat_hi_d = 1'b1;
                        sat_lo_d = 1'b0;
                    end else begin
                        duty_d   = pi_sum[PWM_BITS-1:0];
                        sat_hi_d = 1'b0;
                        sat_lo_d = 1'b0;
                    end
                    state_d = ST_CLAMP;
                end
                ST_CLAMP: state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            err_q      <= '0;
            integ_q    <= '0;
            duty_q     <= '0;
            sat_hi_q   <= 1'b0;
            sat_lo_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            err_q      <= err_d;
            integ_q    <= integ_d;
            duty_q     <= duty_d;
            sat_hi_q   <= sat_hi_d;
            sat_lo_q   <= sat_lo_d;
        end
    end

    pi_pwm_regulator_pwm #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm (
        .clock_i  (clock_i),
        .reset_i  (reset_i),
        .enable_i (enable_i),
        .duty_i   (duty_q),
        .pwm_o    (pwm_out_o)
    );

    assign duty_o      = duty_q;
    assign update_o    = (state_q == ST_CLAMP) && enable_i;
    assign saturated_o = sat_hi_q || sat_lo_q;

endmodule
